// File: rtl/cc_serializer_unit.sv
// Serializes 512-bit cache lines from a show-ahead FIFO into 8 x 64-bit R-channel beats.
// The burst starts at the line's critical word and wraps around; bursts run back-to-back.
module cc_serializer_unit (
   input  logic         clk,
   input  logic         rst,
   input  logic         fifo_empty_i,
   input  logic [514:0] fifo_rdata_i,
   output logic         fifo_rden_o,
   output logic [63:0]  inct_rdata_o,
   output logic         inct_rlast_o,
   output logic         inct_rvalid_o,
   input  logic         inct_rready_i,
   output logic         busy_o
);

   typedef enum logic {ST_IDLE, ST_SEND} state_t;

   state_t       r_state;
   logic [2:0]   r_cnt;
   logic [2:0]   r_off;
   logic [511:0] r_line;

   state_t       w_state_nxt;
   logic         w_pop;
   logic         w_xfer;
   logic         w_last;
   logic [2:0]   w_idx;

   // Word index wraps naturally in 3 bits, giving the critical-word-first order.
   assign w_idx  = r_off + r_cnt;
   assign w_last = (r_state == ST_SEND) && (r_cnt == 3'd7);
   assign w_xfer = (r_state == ST_SEND) && inct_rready_i;

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!fifo_empty_i && !rst) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            // Pop the next line on the final handshake so bursts stay contiguous.
            if (w_xfer && w_last) begin
               if (!fifo_empty_i && !rst) begin
                  w_pop = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 3'd0;
         r_off   <= 3'd0;
         r_line  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pop) begin
            r_line <= fifo_rdata_i[511:0];
            r_off  <= fifo_rdata_i[514:512];
            r_cnt  <= 3'd0;
         end else if (w_xfer) begin
            r_cnt <= r_cnt + 3'd1;
         end
      end
   end

   assign fifo_rden_o   = w_pop;
   assign inct_rvalid_o = (r_state == ST_SEND);
   assign inct_rlast_o  = w_last;
   assign inct_rdata_o  = (r_state == ST_SEND) ? r_line[w_idx*64 +: 64] : 64'h0;
   assign busy_o        = (r_state == ST_SEND);

endmodule

// File: tb/tb_cc_serializer_unit.sv
// Bench for cc_serializer_unit: FIFO model plus a beats-remaining reference model.
module tb_cc_serializer_unit;

   logic         clk = 1'b0;
   logic         rst;
   logic         fifo_empty_i;
   logic [514:0] fifo_rdata_i;
   logic         fifo_rden_o;
   logic [63:0]  inct_rdata_o;
   logic         inct_rlast_o;
   logic         inct_rvalid_o;
   logic         inct_rready_i;
   logic         busy_o;

   cc_serializer_unit dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty_i (fifo_empty_i),
      .fifo_rdata_i (fifo_rdata_i),
      .fifo_rden_o  (fifo_rden_o),
      .inct_rdata_o (inct_rdata_o),
      .inct_rlast_o (inct_rlast_o),
      .inct_rvalid_o(inct_rvalid_o),
      .inct_rready_i(inct_rready_i),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   logic [514:0] fq[$];
   logic [63:0]  acc_q[$];
   logic [511:0] cur_line;
   int           cur_off;
   int           rem;
   int           n_pass;
   int           n_total;
   int           n_vld;
   int           n_rden;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic drive_fifo();
      fifo_empty_i = (fq.size() == 0);
      fifo_rdata_i = (fq.size() != 0) ? fq[0] : '0;
   endtask

   function automatic logic [514:0] mk_entry(input logic [63:0] base, input int off, input bit rnd);
      logic [514:0] e;
      e = '0;
      for (int k = 0; k < 8; k++)
         e[k*64 +: 64] = rnd ? {$urandom, $urandom} : base + 64'(k);
      e[514:512] = 3'(off);
      return e;
   endfunction

   task automatic push(input logic [514:0] e);
      fq.push_back(e);
      drive_fifo();
   endtask

   // One clock: check every output against the model, then advance the model.
   task automatic tick(input string tag);
      logic        e_vld, e_last, e_rden;
      logic [63:0] e_dat;
      int          idx;
      @(negedge clk);
      e_vld  = (rem != 0);
      idx    = (cur_off + 8 - rem) % 8;
      e_dat  = e_vld ? cur_line[idx*64 +: 64] : 64'h0;
      e_last = (rem == 1);
      e_rden = !rst && (fq.size() != 0) && (rem == 0 || (rem == 1 && inct_rready_i));
      chk({tag, ".rvalid"}, 64'(inct_rvalid_o), 64'(e_vld));
      chk({tag, ".rdata"},  inct_rdata_o, e_dat);
      chk({tag, ".rlast"},  64'(inct_rlast_o), 64'(e_last));
      chk({tag, ".rden"},   64'(fifo_rden_o), 64'(e_rden));
      chk({tag, ".busy"},   64'(busy_o), 64'(e_vld));
      if (inct_rvalid_o && inct_rready_i) acc_q.push_back(inct_rdata_o);
      if (inct_rvalid_o) n_vld++;
      if (fifo_rden_o) n_rden++;
      @(posedge clk);
      if (rst) begin
         rem = 0;
      end else begin
         if (rem != 0 && inct_rready_i) rem--;
         if (e_rden) begin
            cur_line = fq[0][511:0];
            cur_off  = int'(fq[0][514:512]);
            rem      = 8;
            void'(fq.pop_front());
         end
      end
      #1 drive_fifo();
   endtask

   task automatic run_idle(input string tag, input int max, output int cyc);
      cyc = 0;
      do begin
         tick(tag);
         cyc++;
      end while ((rem != 0 || fq.size() != 0) && cyc < max);
      chk({tag, ".done"}, 64'(rem == 0 && fq.size() == 0), 64'd1);
   endtask

   initial begin
      int           cyc;
      int           n_push;
      logic [514:0] e;
      logic [63:0]  w2;
      n_pass = 0; n_total = 0; n_vld = 0; n_rden = 0;
      rem = 0; cur_off = 0; cur_line = '0;
      rst = 1'b1;
      inct_rready_i = 1'b1;
      push(mk_entry(64'h1234_0000_0000_0000, 3, 1'b0));
      @(posedge clk); @(posedge clk); #1;

      // Reset with a non-empty FIFO: nothing may be popped.
      tick("rst_hold");
      tick("rst_hold");
      fq.delete(); drive_fifo();
      tick("rst_empty");
      rst = 1'b0;

      // Empty FIFO after reset: stay idle.
      n_vld = 0; n_rden = 0;
      for (int i = 0; i < 20; i++) tick("idle20");
      chk("idle20.nvld", 64'(n_vld), 64'd0);
      chk("idle20.nrden", 64'(n_rden), 64'd0);

      // Offset 0, rready high.
      acc_q.delete();
      push(mk_entry(64'hA000_0000_0000_0000, 0, 1'b0));
      run_idle("off0", 40, cyc);
      chk("off0.cycles", 64'(cyc), 64'd9);
      chk("off0.nbeats", 64'(acc_q.size()), 64'd8);
      for (int k = 0; k < 8 && k < acc_q.size(); k++)
         chk($sformatf("off0.beat%0d", k), acc_q[k], 64'hA000_0000_0000_0000 + 64'(k));

      // Offset 5: w5,w6,w7,w0..w4.
      acc_q.delete();
      push(mk_entry(64'hA000_0000_0000_0000, 5, 1'b0));
      run_idle("off5", 40, cyc);
      chk("off5.nbeats", 64'(acc_q.size()), 64'd8);
      for (int k = 0; k < 8 && k < acc_q.size(); k++)
         chk($sformatf("off5.beat%0d", k), acc_q[k], 64'hA000_0000_0000_0000 + 64'((k + 5) % 8));

      // Alternating rready: 16 valid cycles for 8 beats.
      acc_q.delete(); n_vld = 0;
      push(mk_entry(64'hA000_0000_0000_0000, 0, 1'b0));
      inct_rready_i = 1'b1;
      cyc = 0;
      do begin
         tick("alt");
         inct_rready_i = ~inct_rready_i;
         cyc++;
      end while ((rem != 0 || fq.size() != 0) && cyc < 60);
      chk("alt.nvld", 64'(n_vld), 64'd16);
      chk("alt.nbeats", 64'(acc_q.size()), 64'd8);
      for (int k = 0; k < 8 && k < acc_q.size(); k++)
         chk($sformatf("alt.beat%0d", k), acc_q[k], 64'hA000_0000_0000_0000 + 64'(k));

      // Two queued entries back-to-back, no bubble.
      inct_rready_i = 1'b1;
      acc_q.delete(); n_vld = 0; n_rden = 0;
      push(mk_entry(64'h0, $urandom_range(7), 1'b1));
      push(mk_entry(64'h0, $urandom_range(7), 1'b1));
      run_idle("b2b", 60, cyc);
      chk("b2b.cycles", 64'(cyc), 64'd17);
      chk("b2b.nvld", 64'(n_vld), 64'd16);
      chk("b2b.nrden", 64'(n_rden), 64'd2);

      // Reset one cycle after the third handshake, then an offset-2 line.
      acc_q.delete();
      push(mk_entry(64'h0, $urandom_range(7), 1'b1));
      cyc = 0;
      while (acc_q.size() < 3 && cyc < 20) begin
         tick("mid");
         cyc++;
      end
      chk("mid.hs3", 64'(acc_q.size()), 64'd3);
      rst = 1'b1;
      inct_rready_i = 1'b0;
      e = mk_entry(64'h0, 2, 1'b1);
      w2 = e[2*64 +: 64];
      push(e);
      tick("mid_rst");
      tick("mid_rst");
      chk("mid_rst.vld", 64'(inct_rvalid_o), 64'd0);
      rst = 1'b0;
      inct_rready_i = 1'b1;
      acc_q.delete();
      run_idle("post_rst", 40, cyc);
      chk("post_rst.nbeats", 64'(acc_q.size()), 64'd8);
      if (acc_q.size() != 0) chk("post_rst.first", acc_q[0], w2);

      // Random traffic: random offsets, push timing and rready.
      acc_q.delete();
      n_push = 0;
      for (int i = 0; i < 400; i++) begin
         if (fq.size() < 3 && $urandom_range(3) == 0) begin
            push(mk_entry(64'h0, $urandom_range(7), 1'b1));
            n_push++;
         end
         inct_rready_i = ($urandom_range(3) != 0);
         tick("rnd");
      end
      inct_rready_i = 1'b1;
      run_idle("rnd_drain", 200, cyc);
      chk("rnd.nbeats", 64'(acc_q.size()), 64'(8 * n_push));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cc_serializer_unit.md
CC_SERIALIZER_UNIT -- requirements
Module: cc_serializer_unit

Interface
REQ-001 Parameters: none; the line is 512 bits, the beat is 64 bits and the burst is 8 beats, all fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 fifo_empty_i  input  1  hit-data FIFO empty flag.
REQ-005 fifo_rdata_i  input  515  show-ahead FIFO head: [514:512]=critical-word offset, [511:0]=cache line (word k at [64k+63:64k]).
REQ-006 fifo_rden_o  output  1  FIFO pop strobe; head consumed on the cycle it is high.
REQ-007 inct_rdata_o  output  64  R-channel beat data to requester.
REQ-008 inct_rlast_o  output  1  last beat of burst.
REQ-009 inct_rvalid_o  output  1  beat valid.
REQ-010 inct_rready_i  input  1  requester accepts beat.
REQ-011 busy_o  output  1  high while a burst is in progress (state SEND).

Function
REQ-012 Two states: IDLE, SEND; a registered 3-bit beat counter cnt, a registered 512-bit line buffer and a registered 3-bit offset.
REQ-013 IDLE: fifo_rden_o = !fifo_empty_i (combinational); on pop, latch line and offset, clear cnt, go to SEND next cycle.
REQ-014 IDLE with fifo_empty_i=1: no pop, remain IDLE, all outputs low/zero.
REQ-015 Latency: first inct_rvalid_o asserted exactly 1 cycle after the pop cycle.
REQ-016 SEND: inct_rvalid_o=1; inct_rdata_o = line word ((offset+cnt) mod 8), computed with 3-bit wrap-around addition.
REQ-017 inct_rlast_o = 1 iff state is SEND and cnt==7.
REQ-018 Beat transfer occurs only on inct_rvalid_o & inct_rready_i; then cnt increments by 1.
REQ-019 While inct_rvalid_o=1 and inct_rready_i=0: inct_rdata_o, inct_rlast_o and inct_rvalid_o hold unchanged; cnt holds.
REQ-020 Last-beat transfer (cnt==7 & inct_rready_i) with fifo_empty_i=0: fifo_rden_o=1 in the same cycle, the new line/offset are latched, cnt clears, the block stays in SEND, and no idle bubble occurs between bursts.
REQ-021 Last-beat transfer with fifo_empty_i=1: return to IDLE; inct_rvalid_o low next cycle.
REQ-022 fifo_rden_o is never asserted in SEND except under REQ-020; it is never asserted when fifo_empty_i=1.
REQ-023 inct_rdata_o drives 64'h0 and inct_rlast_o drives 0 whenever inct_rvalid_o=0.
REQ-024 Each popped FIFO entry produces exactly 8 transferred beats, each line word exactly once.

Reset
REQ-025 With rst=1 at a clock edge: state becomes IDLE, cnt=0, offset=0, line buffer=0.
REQ-026 While rst=1: fifo_rden_o=0 regardless of fifo_empty_i; the FIFO is never popped during reset.
REQ-027 Post-reset outputs: inct_rvalid_o=0, inct_rlast_o=0, inct_rdata_o=0, busy_o=0.
REQ-028 Reset mid-burst discards the remaining beats of the in-flight line; that line is not replayed.

Verification
REQ-029 Offset 0, word k = 64'hA000_0000_0000_000k, rready=1 -> beats A..0 through A..7 in 8 consecutive cycles, starting 1 cycle after the pop; rlast on beat 8 only.
REQ-030 Offset 5, same line -> beat order w5,w6,w7,w0,w1,w2,w3,w4; rlast coincides with w4.
REQ-031 Offset 0, rready alternating 0,1,0,1... -> each beat held stable until accepted; 8 beats complete in 16 SEND cycles; cnt never skips.
REQ-032 Two entries queued, rready=1 -> 16 contiguous valid beats; fifo_rden_o pulses at the initial IDLE pop and again in the cycle of the first rlast handshake; rvalid has no gap.
REQ-033 Reset asserted 1 cycle after the 3rd beat handshake -> rvalid=0, rlast=0 and rdata=0 the next cycle; no pop during reset; a later entry with offset 2 starts at w2.
REQ-034 FIFO held empty for 20 cycles after reset -> fifo_rden_o, inct_rvalid_o and busy_o remain 0 throughout.
